// File: rtl/branch_history_table_if.sv
// Fetch-side lookup and EX-side resolution signals of the branch history table.
// The master drives the PCs and resolution info; the slave (the table) returns prediction and recovery.
interface branch_history_table_if;
    logic [31:0] pc;
    logic [31:0] pc_predict;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        predict_fail;
    logic [31:0] pc_new;

    modport master (
        output pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        input  pc_predict, pred_taken, predict_fail, pc_new
    );

    modport slave (
        input  pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        output pc_predict, pred_taken, predict_fail, pc_new
    );
endinterface

// File: rtl/branch_history_table.sv
// Direct-mapped branch history table with 2-bit saturating counters over a 4 KB
// instruction space; 0-cycle lookup, registered update, combinational recovery.
module branch_history_table #(
    parameter int IDX_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_history_table_if.slave bus
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = 10 - IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [9:0]       target;
        logic [1:0]       ctr;
    } entry_t;

    entry_t tbl [ENTRIES];

    logic [IDX_W-1:0] idx, upd_idx;
    logic [TAG_W-1:0] tag, upd_tag;
    logic             hit, upd_hit;
    entry_t           rd, upd_rd;

    assign idx     = bus.pc[IDX_W+1:2];
    assign tag     = bus.pc[11:IDX_W+2];
    assign upd_idx = bus.upd_pc[IDX_W+1:2];
    assign upd_tag = bus.upd_pc[11:IDX_W+2];
    assign rd      = tbl[idx];
    assign upd_rd  = tbl[upd_idx];
    assign hit     = rd.valid && (rd.tag == tag);
    assign upd_hit = upd_rd.valid && (upd_rd.tag == upd_tag);

    // Lookup reads the array directly, so a same-cycle update is not visible until the next cycle.
    assign bus.pred_taken = hit && rd.ctr[1];
    assign bus.pc_predict = bus.pred_taken ? {20'b0, rd.target, 2'b00}
                                           : {20'b0, bus.pc[11:2] + 10'd1, 2'b00};

    assign bus.predict_fail = bus.upd_valid &&
        ((bus.upd_taken != bus.upd_pred_taken) ||
         (bus.upd_taken && (bus.upd_target[11:2] != bus.upd_pred_target[11:2])));
    assign bus.pc_new = bus.upd_taken ? {20'b0, bus.upd_target[11:2], 2'b00}
                                      : {20'b0, bus.upd_pc[11:2] + 10'd1, 2'b00};

    // Only pc[11:2] is meaningful in a 4 KB word-aligned space.
    logic unused_bits;
    assign unused_bits = ^{bus.pc[31:12], bus.pc[1:0], bus.upd_pc[31:12], bus.upd_pc[1:0],
                           bus.upd_target[31:12], bus.upd_target[1:0],
                           bus.upd_pred_target[31:12], bus.upd_pred_target[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i].valid <= 1'b0;
                tbl[i].ctr   <= 2'b00;
            end
        end else if (bus.upd_valid) begin
            if (upd_hit) begin
                if (bus.upd_taken) begin
                    if (upd_rd.ctr != 2'b11) tbl[upd_idx].ctr <= upd_rd.ctr + 2'd1;
                    tbl[upd_idx].target <= bus.upd_target[11:2];
                end else if (upd_rd.ctr != 2'b00) begin
                    tbl[upd_idx].ctr <= upd_rd.ctr - 2'd1;
                end
            end else if (bus.upd_taken) begin
                // Taken miss replaces whatever aliased into this slot, starting weakly taken.
                tbl[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: bus.upd_target[11:2], ctr: 2'b10};
            end
        end
    end
endmodule

// File: tb/tb_branch_history_table.sv
// Vector table driven into the table; expected outputs queued at drive time and
// popped/compared on the falling edge.
module tb_branch_history_table;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_history_table_if bif ();
    branch_history_table #(.IDX_W(4)) dut (.clk(clk), .rst(rst), .bus(bif.slave));

    typedef struct {
        bit          rst;
        logic [31:0] pc;
        bit          uv;
        logic [31:0] upc;
        bit          ut;
        logic [31:0] utgt;
        bit          upt;
        logic [31:0] uptgt;
        bit          chk;
        bit          ept;
        logic [31:0] epp;
        bit          ef;
        logic [31:0] enew;
    } vec_t;

    typedef struct {
        int          id;
        bit          ept;
        logic [31:0] epp;
        bit          ef;
        logic [31:0] enew;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(bit r, logic [31:0] pc, bit uv, logic [31:0] upc, bit ut,
                                logic [31:0] utgt, bit upt, logic [31:0] uptgt, bit chk,
                                bit ept, logic [31:0] epp, bit ef, logic [31:0] enew);
        vec_t v;
        v.rst = r; v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.upt = upt; v.uptgt = uptgt; v.chk = chk; v.ept = ept; v.epp = epp;
        v.ef = ef; v.enew = enew;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int id);
        exp_t e;
        @(posedge clk);
        #1;
        rst                 = v.rst;
        bif.pc              = v.pc;
        bif.upd_valid       = v.uv;
        bif.upd_pc          = v.upc;
        bif.upd_taken       = v.ut;
        bif.upd_target      = v.utgt;
        bif.upd_pred_taken  = v.upt;
        bif.upd_pred_target = v.uptgt;
        if (v.chk) begin
            e.id = id; e.ept = v.ept; e.epp = v.epp; e.ef = v.ef; e.enew = v.enew;
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (bif.pred_taken !== e.ept) begin
                errors++;
                $display("FAIL v%0d pred_taken: got %b want %b", e.id, bif.pred_taken, e.ept);
            end
            checks++;
            if (bif.pc_predict !== e.epp) begin
                errors++;
                $display("FAIL v%0d pc_predict: got %h want %h", e.id, bif.pc_predict, e.epp);
            end
            checks++;
            if (bif.predict_fail !== e.ef) begin
                errors++;
                $display("FAIL v%0d predict_fail: got %b want %b", e.id, bif.predict_fail, e.ef);
            end
            if (e.ef) begin
                checks++;
                if (bif.pc_new !== e.enew) begin
                    errors++;
                    $display("FAIL v%0d pc_new: got %h want %h", e.id, bif.pc_new, e.enew);
                end
            end
        end
    end

    initial begin
        int n;
        vec_t v;
        rst = 1'b1;
        bif.pc = '0; bif.upd_valid = 1'b0; bif.upd_pc = '0; bif.upd_taken = 1'b0;
        bif.upd_target = '0; bif.upd_pred_taken = 1'b0; bif.upd_pred_target = '0;

        //             rst pc            uv upc           ut utgt          upt uptgt   chk ept epp           ef enew
        vecs.push_back(mk(1, 32'h40,       0, 0,            0, 0,            0, 0,      0, 0, 0,            0, 0));
        vecs.push_back(mk(0, 32'h40,       0, 0,            0, 0,            0, 0,      1, 0, 32'h44,       0, 0));
        vecs.push_back(mk(0, 32'hFFC,      0, 0,            0, 0,            0, 0,      1, 0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 32'h40,       1, 32'h40,       1, 32'h100,      0, 32'h44, 1, 0, 32'h44,       1, 32'h100));
        vecs.push_back(mk(0, 32'h40,       0, 0,            0, 0,            0, 0,      1, 1, 32'h100,      0, 0));
        vecs.push_back(mk(0, 32'h40,       1, 32'h40,       0, 0,            1, 32'h100,1, 1, 32'h100,      1, 32'h44));
        vecs.push_back(mk(0, 32'h40,       1, 32'h40,       0, 0,            1, 32'h100,1, 0, 32'h44,       1, 32'h44));
        vecs.push_back(mk(0, 32'h40,       1, 32'h40,       0, 0,            0, 32'h44, 1, 0, 32'h44,       0, 0));
        vecs.push_back(mk(0, 32'h40,       1, 32'h40,       1, 32'h100,      0, 32'h44, 1, 0, 32'h44,       1, 32'h100));
        vecs.push_back(mk(0, 32'h40,       0, 0,            0, 0,            0, 0,      1, 0, 32'h44,       0, 0));
        vecs.push_back(mk(0, 32'h40,       1, 32'h40,       1, 32'h100,      0, 32'h44, 1, 0, 32'h44,       1, 32'h100));
        vecs.push_back(mk(0, 32'h40,       1, 32'h40,       1, 32'h100,      1, 32'h100,1, 1, 32'h100,      0, 0));
        vecs.push_back(mk(0, 32'h40,       1, 32'h40,       1, 32'h100,      1, 32'h100,1, 1, 32'h100,      0, 0));
        vecs.push_back(mk(0, 32'h40,       1, 32'h40,       0, 0,            1, 32'h100,1, 1, 32'h100,      1, 32'h44));
        vecs.push_back(mk(0, 32'h40,       0, 0,            0, 0,            0, 0,      1, 1, 32'h100,      0, 0));
        vecs.push_back(mk(0, 32'h40,       1, 32'h40,       1, 32'h180,      1, 32'h100,1, 1, 32'h100,      1, 32'h180));
        vecs.push_back(mk(0, 32'h40,       0, 0,            0, 0,            0, 0,      1, 1, 32'h180,      0, 0));
        vecs.push_back(mk(0, 32'h80,       0, 0,            0, 0,            0, 0,      1, 0, 32'h84,       0, 0));
        vecs.push_back(mk(0, 32'h80,       1, 32'h80,       1, 32'h200,      0, 32'h84, 1, 0, 32'h84,       1, 32'h200));
        vecs.push_back(mk(0, 32'h40,       0, 0,            0, 0,            0, 0,      1, 0, 32'h44,       0, 0));
        vecs.push_back(mk(0, 32'h80,       0, 0,            0, 0,            0, 0,      1, 1, 32'h200,      0, 0));
        vecs.push_back(mk(0, 32'h80,       1, 32'h40,       0, 0,            0, 32'h44, 1, 1, 32'h200,      0, 0));
        vecs.push_back(mk(0, 32'h80,       0, 0,            0, 0,            0, 0,      1, 1, 32'h200,      0, 0));
        vecs.push_back(mk(0, 32'h1FFC,     1, 32'hFFC,      0, 0,            1, 32'h100,1, 0, 32'h0,        1, 32'h0));
        vecs.push_back(mk(0, 32'h44,       1, 32'h44,       1, 32'hABC00120, 0, 32'h48, 1, 0, 32'h48,       1, 32'h120));
        vecs.push_back(mk(0, 32'hF0000044, 0, 0,            0, 0,            0, 0,      1, 1, 32'h120,      0, 0));
        vecs.push_back(mk(0, 32'h44,       1, 32'h44,       1, 32'h123,      1, 32'h120,1, 1, 32'h120,      0, 0));
        vecs.push_back(mk(0, 32'h40,       1, 32'h40,       1, 32'h300,      0, 32'h44, 1, 0, 32'h44,       1, 32'h300));
        vecs.push_back(mk(0, 32'h40,       0, 0,            0, 0,            0, 0,      1, 1, 32'h300,      0, 0));
        vecs.push_back(mk(1, 32'h40,       1, 32'h80,       1, 32'h200,      0, 32'h84, 1, 1, 32'h300,      1, 32'h200));
        vecs.push_back(mk(0, 32'h80,       0, 0,            0, 0,            0, 0,      1, 0, 32'h84,       0, 0));
        vecs.push_back(mk(0, 32'h40,       0, 0,            0, 0,            0, 0,      1, 0, 32'h44,       0, 0));
        vecs.push_back(mk(0, 32'h44,       0, 0,            0, 0,            0, 0,      1, 0, 32'h48,       0, 0));

        n = vecs.size();
        for (int i = 0; i < n; i++) apply(vecs[i], i);

        // Idle resolution bus carrying garbage must neither flag nor train.
        for (int i = 0; i < 8; i++) begin
            v = mk(0, 32'h40, 0, $urandom, 1'($urandom), $urandom, 1'($urandom), $urandom,
                   1, 0, 32'h44, 0, 0);
            apply(v, 100 + i);
        end
        apply(mk(0, 32'h40, 0, 0, 0, 0, 0, 0, 1, 0, 32'h44, 0, 0), 200);

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
